// File: rtl/dpc_pkg.sv
// Shared types and constants for the DPC stream controller.
//   state_e : controller FSM states
//   MIN_W/H : smallest frame the datapath can window (3x3 kernel, 2 rows)
//   cnt_t   : counter type at the default counter width
//   lat_t   : double-width type holding latency and pixel-count products
package dpc_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam int MIN_W = 3;
  localparam int MIN_H = 2;

  localparam int CNT_W = 12;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [2*CNT_W-1:0] lat_t;

endpackage

// File: rtl/dpc_go_sync.sv
// Brings the asynchronous go level into the clock domain and produces
// single-cycle rise/fall pulses from the synchronised level.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   go_i   : asynchronous run request level
//   rise_o : 1-cycle pulse on a synchronised 0->1 transition
//   fall_o : 1-cycle pulse on a synchronised 1->0 transition
module dpc_go_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic go_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= go_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/dpc_stream_ctrl.sv
// Frame/stream controller for the DPC kernel. Accepts an AXIS pixel stream,
// advances the linebuf/window/filter datapath via pipe_en, and after the last
// input pixel flushes the pipeline (pipe_flush) so the final L = LAT_ROWS*W +
// LAT_FIXED pixels still reach the output stream.
//   axis_aclk, reset      : clock, asynchronous active-high reset
//   go                    : asynchronous run request level
//   cfg_width/cfg_height  : frame size, sampled on the SOF beat
//   s_axis_*              : input stream (tuser = SOF, tlast = EOL)
//   m_axis_*              : output stream (tuser = first pixel, tlast = EOL)
//   pipe_en/pipe_flush    : datapath advance / bubble-insert controls
//   in_*/out_* counters   : input/output pixel positions and input edge flags
//   synced_go             : controller active (ARM/RUN/FLUSH)
//   frame_done, err_*     : single-cycle status pulses
module dpc_stream_ctrl
  import dpc_pkg::*;
#(
  parameter int CNT_WIDTH = 12,
  parameter int LAT_ROWS  = 1,
  parameter int LAT_FIXED = 7
) (
  input  logic                 axis_aclk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [CNT_WIDTH-1:0] cfg_width,
  input  logic [CNT_WIDTH-1:0] cfg_height,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tuser,
  input  logic                 s_axis_tlast,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tlast,
  output logic                 pipe_en,
  output logic                 pipe_flush,
  output logic [CNT_WIDTH-1:0] in_hcnt,
  output logic [CNT_WIDTH-1:0] in_vcnt,
  output logic                 in_first_row,
  output logic                 in_last_row,
  output logic                 in_first_col,
  output logic                 in_last_col,
  output logic [CNT_WIDTH-1:0] out_hcnt,
  output logic [CNT_WIDTH-1:0] out_vcnt,
  output logic                 synced_go,
  output logic                 frame_done,
  output logic                 err_cfg,
  output logic                 err_sof,
  output logic                 err_eol
);

  localparam int CW = CNT_WIDTH;
  localparam int LW = 2 * CNT_WIDTH;

  state_e         state_q, state_d;
  logic           stop_pend_q, stop_pend_d;
  logic [CW-1:0]  w_q, w_d, h_q, h_d;
  logic [LW-1:0]  lat_q, lat_d, fill_q, fill_d;
  logic [CW-1:0]  in_h_q, in_h_d, in_v_q, in_v_d;
  logic [CW-1:0]  out_h_q, out_h_d, out_v_q, out_v_d;
  logic           go_rise, go_fall;
  logic           s_rdy, m_vld, s_fire, m_fire, filled;

  // Raster step: column wraps at the last column and bumps the row.
  function automatic logic [2*CNT_WIDTH-1:0] step_pos(
    input logic [CNT_WIDTH-1:0] h, v, hl);
    if (h == hl) return {v + CW'(1), {CNT_WIDTH{1'b0}}};
    else         return {v, h + CW'(1)};
  endfunction

  dpc_go_sync u_go_sync (
    .clk_i  (axis_aclk),
    .rst_i  (reset),
    .go_i   (go),
    .rise_o (go_rise),
    .fall_o (go_fall)
  );

  wire [CW-1:0] w_last   = w_q - CW'(1);
  wire [CW-1:0] h_last   = h_q - CW'(1);
  wire [LW-1:0] cfg_lat  = LW'(LAT_ROWS) * LW'(cfg_width) + LW'(LAT_FIXED);
  wire [LW-1:0] cfg_area = LW'(cfg_width) * LW'(cfg_height);
  // A frame no larger than the pipeline latency could never produce an
  // output before it ends, so it is rejected along with undersized frames.
  wire cfg_bad = (cfg_width < CW'(MIN_W)) || (cfg_height < CW'(MIN_H)) ||
                 (cfg_area <= cfg_lat);
  wire in_at_end  = (in_h_q == w_last) && (in_v_q == h_last);
  wire out_at_end = (out_h_q == w_last) && (out_v_q == h_last);

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    w_d = w_q;  h_d = h_q;  lat_d = lat_q;  fill_d = fill_q;
    in_h_d = in_h_q;  in_v_d = in_v_q;  out_h_d = out_h_q;  out_v_d = out_v_q;
    s_rdy = 1'b0;  m_vld = 1'b0;  s_fire = 1'b0;  m_fire = 1'b0;  filled = 1'b0;
    pipe_en = 1'b0;  pipe_flush = 1'b0;  frame_done = 1'b0;
    err_cfg = 1'b0;  err_sof = 1'b0;  err_eol = 1'b0;

    if (go_fall && state_q != STOP) stop_pend_d = 1'b1;

    unique case (state_q)
      STOP: if (go_rise) state_d = ARM;

      ARM: begin
        s_rdy = 1'b1;
        in_h_d = '0;  in_v_d = '0;  out_h_d = '0;  out_v_d = '0;  fill_d = '0;
        if (stop_pend_q) begin
          state_d = STOP;
        end else if (s_axis_tvalid && s_axis_tuser) begin
          w_d = cfg_width;  h_d = cfg_height;  lat_d = cfg_lat;
          if (cfg_bad) begin
            err_cfg = 1'b1;
          end else begin
            // SOF beat is pixel (0,0); W >= MIN_W so the next column is 1.
            pipe_en = 1'b1;
            fill_d  = LW'(1);
            in_h_d  = CW'(1);
            state_d = RUN;
          end
        end
      end

      RUN: begin
        filled = (fill_q >= lat_q);
        if (filled) begin
          // Pipeline full: every accepted pixel pushes one out, so the
          // input can only move when the output does.
          m_vld = s_axis_tvalid;
          s_rdy = m_axis_tready;
        end else begin
          s_rdy = 1'b1;
        end
        s_fire  = s_axis_tvalid & s_rdy;
        m_fire  = m_vld & m_axis_tready;
        pipe_en = s_fire;
        if (s_fire) begin
          if (!filled) fill_d = fill_q + LW'(1);
          {in_v_d, in_h_d} = step_pos(in_h_q, in_v_q, w_last);
          err_sof = s_axis_tuser && !(in_h_q == '0 && in_v_q == '0);
          err_eol = s_axis_tlast != (in_h_q == w_last);
          if (in_at_end) state_d = FLUSH;
        end
        if (m_fire) {out_v_d, out_h_d} = step_pos(out_h_q, out_v_q, w_last);
      end

      FLUSH: begin
        m_vld      = 1'b1;
        pipe_flush = 1'b1;
        m_fire     = m_axis_tready;
        pipe_en    = m_fire;
        if (m_fire) begin
          {out_v_d, out_h_d} = step_pos(out_h_q, out_v_q, w_last);
          if (out_at_end) begin
            frame_done = 1'b1;
            state_d    = (stop_pend_q || go_fall) ? STOP : ARM;
          end
        end
      end

      default: state_d = STOP;
    endcase

    if (state_d == STOP) stop_pend_d = 1'b0;
  end

  always_ff @(posedge axis_aclk or posedge reset) begin
    if (reset) begin
      state_q     <= STOP;
      stop_pend_q <= 1'b0;
      w_q <= '0;  h_q <= '0;  lat_q <= '0;  fill_q <= '0;
      in_h_q <= '0;  in_v_q <= '0;  out_h_q <= '0;  out_v_q <= '0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      w_q <= w_d;  h_q <= h_d;  lat_q <= lat_d;  fill_q <= fill_d;
      in_h_q <= in_h_d;  in_v_q <= in_v_d;  out_h_q <= out_h_d;  out_v_q <= out_v_d;
    end
  end

  assign s_axis_tready = s_rdy;
  assign m_axis_tvalid = m_vld;
  assign m_axis_tuser  = m_vld && (out_h_q == '0) && (out_v_q == '0);
  assign m_axis_tlast  = m_vld && (out_h_q == w_last);
  assign in_hcnt  = in_h_q;
  assign in_vcnt  = in_v_q;
  assign out_hcnt = out_h_q;
  assign out_vcnt = out_v_q;
  assign synced_go = (state_q != STOP);

  // Edge flags only mean something while a frame is being received.
  wire run_st = (state_q == RUN);
  assign in_first_row = run_st && (in_v_q == '0);
  assign in_last_row  = run_st && (in_v_q == h_last);
  assign in_first_col = run_st && (in_h_q == '0);
  assign in_last_col  = run_st && (in_h_q == w_last);

endmodule

// File: tb/tb_dpc_stream_ctrl.sv
// Directed bench for dpc_stream_ctrl at W=8, H=6, L=15.
module tb_dpc_stream_ctrl;

  localparam int CW = 12;

  logic          axis_aclk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic [CW-1:0] cfg_width = '0, cfg_height = '0;
  logic          s_axis_tvalid = 1'b0, s_axis_tuser = 1'b0, s_axis_tlast = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic          s_axis_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic          pipe_en, pipe_flush;
  logic [CW-1:0] in_hcnt, in_vcnt, out_hcnt, out_vcnt;
  logic          in_first_row, in_last_row, in_first_col, in_last_col;
  logic          synced_go, frame_done, err_cfg, err_sof, err_eol;

  dpc_stream_ctrl #(.CNT_WIDTH(CW), .LAT_ROWS(1), .LAT_FIXED(7)) dut (
    .axis_aclk(axis_aclk), .reset(reset), .go(go),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .pipe_en(pipe_en), .pipe_flush(pipe_flush),
    .in_hcnt(in_hcnt), .in_vcnt(in_vcnt),
    .in_first_row(in_first_row), .in_last_row(in_last_row),
    .in_first_col(in_first_col), .in_last_col(in_last_col),
    .out_hcnt(out_hcnt), .out_vcnt(out_vcnt),
    .synced_go(synced_go), .frame_done(frame_done),
    .err_cfg(err_cfg), .err_sof(err_sof), .err_eol(err_eol)
  );

  always #5 axis_aclk = ~axis_aclk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axis_aclk);
    #1;
  endtask

  // Per-frame observations gathered by run_frame.
  int n_out, n_acc, first_vld, flush_n, done_n, done_last, eol_n, sof_n;
  int pos_bad, tu_bad, tl_bad, stab_bad, sof_hcnt;
  bit timed_out, aborted;

  task automatic drive_pix(input int idx, input int w, input int eol_at);
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = (idx == 0);
    s_axis_tlast  = ((idx % w) == w - 1) || (idx == eol_at);
  endtask

  // Streams one W x H frame and scores every output beat against the raster
  // order a correct controller must produce.
  task automatic run_frame(input int w, input int h, input bit stall,
                           input int fall_at, input int eol_at, input int abort_out);
    int idx, cyc, total;
    bit sf, mf, st_prev, tu_prev, tl_prev;
    idx = 0; cyc = 0; total = w * h;
    n_out = 0; n_acc = 0; first_vld = -1; flush_n = 0; done_n = 0; done_last = 0;
    eol_n = 0; sof_n = 0; pos_bad = 0; tu_bad = 0; tl_bad = 0; stab_bad = 0;
    sof_hcnt = -1; timed_out = 0; aborted = 0;
    st_prev = 0; tu_prev = 0; tl_prev = 0;
    cfg_width = CW'(w); cfg_height = CW'(h);
    drive_pix(0, w, eol_at);
    m_axis_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    while (1) begin
      @(negedge axis_aclk);
      if (abort_out >= 0 && pipe_flush && n_out == abort_out) begin
        aborted = 1;
        break;
      end
      sf = s_axis_tvalid && s_axis_tready;
      mf = m_axis_tvalid && m_axis_tready;
      if (m_axis_tvalid && first_vld < 0) first_vld = n_acc;
      if (st_prev && (!m_axis_tvalid || m_axis_tuser != tu_prev || m_axis_tlast != tl_prev))
        stab_bad++;
      st_prev = m_axis_tvalid && !m_axis_tready;
      tu_prev = m_axis_tuser; tl_prev = m_axis_tlast;
      if (sf) begin
        if (idx == 0) sof_hcnt = int'(in_hcnt);
        n_acc++;
        idx++;
      end
      if (mf) begin
        if (int'(out_hcnt) != n_out % w || int'(out_vcnt) != n_out / w) pos_bad++;
        if (m_axis_tuser != (n_out == 0)) tu_bad++;
        if (m_axis_tlast != ((n_out % w) == w - 1)) tl_bad++;
        if (pipe_flush && !s_axis_tready) flush_n++;
        if (frame_done && n_out == total - 1) done_last++;
        n_out++;
      end
      if (frame_done) done_n++;
      if (err_eol) eol_n++;
      if (err_sof) sof_n++;
      cyc++;
      if (n_out == total) break;
      if (cyc > 1000) begin
        timed_out = 1;
        break;
      end
      tick();
      if (idx >= total) begin
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
      end else begin
        drive_pix(idx, w, eol_at);
      end
      if (stall) m_axis_tready = 1'($urandom_range(0, 1));
      if (fall_at >= 0 && idx > fall_at) go = 1'b0;
    end
    if (!aborted) begin
      tick();
      s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
      m_axis_tready = 1'b1;
    end
    chk("frame_timeout", 32'(timed_out), 0);
  endtask

  task automatic wait_arm(input string tag);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge axis_aclk);
      if (s_axis_tready) break;
      n++;
    end
    chk(tag, 32'(s_axis_tready), 1);
    tick();
  endtask

  initial begin
    int rdy_n, pe_n, acc_n;
    logic e1, e2, e3, p1;

    // Reset state: every output low.
    repeat (2) @(negedge axis_aclk);
    chk("rst_s_tready", 32'(s_axis_tready), 0);
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_synced_go", 32'(synced_go), 0);
    chk("rst_flags", 32'({in_first_row, in_last_row, in_first_col, in_last_col}), 0);
    chk("rst_pipe", 32'({pipe_en, pipe_flush}), 0);
    chk("rst_counters", 32'(in_hcnt | in_vcnt | out_hcnt | out_vcnt), 0);
    tick();
    reset = 1'b0;
    tick();
    @(negedge axis_aclk);
    chk("stop_tready", 32'(s_axis_tready), 0);
    tick();

    go = 1'b1;
    wait_arm("arm_after_go");

    // 1: plain frame.
    run_frame(8, 6, 0, -1, -1, -1);
    chk("t1_first_vld", 32'(first_vld), 15);
    chk("t1_outputs", 32'(n_out), 48);
    chk("t1_position", 32'(pos_bad), 0);
    chk("t1_tuser", 32'(tu_bad), 0);
    chk("t1_tlast", 32'(tl_bad), 0);
    chk("t1_flush_outs", 32'(flush_n), 15);
    chk("t1_done_count", 32'(done_n), 1);
    chk("t1_done_on_last", 32'(done_last), 1);
    chk("t1_no_err", 32'(eol_n + sof_n), 0);
    @(negedge axis_aclk);
    chk("t1_back_to_arm", 32'({synced_go, s_axis_tready, m_axis_tvalid}), 32'b110);
    tick();

    // 2: random output backpressure.
    run_frame(8, 6, 1, -1, -1, -1);
    chk("t2_outputs", 32'(n_out), 48);
    chk("t2_position", 32'(pos_bad), 0);
    chk("t2_tuser", 32'(tu_bad), 0);
    chk("t2_tlast", 32'(tl_bad), 0);
    chk("t2_stable", 32'(stab_bad), 0);
    chk("t2_done_count", 32'(done_n), 1);

    // 3: beats before SOF are dropped.
    rdy_n = 0; pe_n = 0;
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
      @(negedge axis_aclk);
      rdy_n += int'(s_axis_tready);
      pe_n  += int'(pipe_en) + int'(in_hcnt);
      tick();
    end
    chk("t3_discard_ready", 32'(rdy_n), 5);
    chk("t3_discard_idle", 32'(pe_n), 0);
    run_frame(8, 6, 0, -1, -1, -1);
    chk("t3_sof_hcnt", 32'(sof_hcnt), 0);
    chk("t3_outputs", 32'(n_out), 48);

    // 5: rejected configurations, then a good frame.
    cfg_width = 12'd4; cfg_height = 12'd2;
    s_axis_tvalid = 1'b1; s_axis_tuser = 1'b1; s_axis_tlast = 1'b0;
    @(negedge axis_aclk);
    e1 = err_cfg; p1 = pipe_en;
    tick();
    cfg_width = 12'd2; cfg_height = 12'd6;
    @(negedge axis_aclk);
    e2 = err_cfg;
    tick();
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
    @(negedge axis_aclk);
    e3 = err_cfg;
    chk("t5_err_area", 32'(e1), 1);
    chk("t5_no_pipe_en", 32'(p1), 0);
    chk("t5_err_width", 32'(e2), 1);
    chk("t5_err_quiet", 32'(e3), 0);
    chk("t5_still_arm", 32'({s_axis_tready, m_axis_tvalid}), 32'b10);
    tick();
    run_frame(8, 6, 0, -1, -1, -1);
    chk("t5_outputs", 32'(n_out), 48);
    chk("t5_position", 32'(pos_bad), 0);

    // 6a: early tlast.
    run_frame(8, 6, 0, -1, 5, -1);
    chk("t6_eol_pulses", 32'(eol_n), 1);
    chk("t6_outputs", 32'(n_out), 48);
    chk("t6_position", 32'(pos_bad), 0);

    // 4: go falls mid-frame; frame completes, then STOP.
    run_frame(8, 6, 0, 20, -1, -1);
    chk("t4_outputs", 32'(n_out), 48);
    chk("t4_done_count", 32'(done_n), 1);
    @(negedge axis_aclk);
    chk("t4_stopped", 32'({synced_go, s_axis_tready}), 0);
    tick();
    acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tuser = 1'b1;
      @(negedge axis_aclk);
      acc_n += int'(s_axis_tready) + int'(pipe_en) + int'(m_axis_tvalid);
      tick();
    end
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
    chk("t4_no_accept", 32'(acc_n), 0);

    go = 1'b1;
    wait_arm("arm_rego");

    // 6b: reset in FLUSH clears outputs immediately.
    run_frame(8, 6, 0, -1, -1, 40);
    chk("t6_reached_flush", 32'(aborted), 1);
    reset = 1'b1;
    #1;
    chk("t6r_outputs", 32'({s_axis_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
                            pipe_en, pipe_flush, synced_go, frame_done}), 0);
    chk("t6r_counters", 32'(in_hcnt | in_vcnt | out_hcnt | out_vcnt), 0);
    tick();
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    reset = 1'b0;
    @(negedge axis_aclk);
    chk("t6r_stop", 32'({synced_go, s_axis_tready}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
